// File: rtl/instruction_loader_pkg.sv
// Shared widths, halt terminator and loader state encoding for the program-load path.
// ST_CHECK exists only when LOADER_CHECKSUM_EN is defined.
package instruction_loader_pkg;

    localparam int NB_DATA = 32;
    localparam int NB_BYTE = 8;
    localparam int NB_ADDR = 8;

    localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd3
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CHECK = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input, instruction-memory write port and fetch/status outputs of the loader.
interface instruction_loader_if #(
    parameter int NB_DATA = instruction_loader_pkg::NB_DATA,
    parameter int NB_BYTE = instruction_loader_pkg::NB_BYTE,
    parameter int NB_ADDR = instruction_loader_pkg::NB_ADDR
);
    logic               i_start;
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               o_wr_enable;
    logic [NB_ADDR-1:0] o_wr_addr;
    logic [NB_DATA-1:0] o_wr_data;
    logic               o_fetch_valid;
    logic               o_busy;
    logic               o_done;
    logic               o_error;
    logic [NB_ADDR:0]   o_word_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_wr_enable, o_wr_addr, o_wr_data, o_fetch_valid,
               o_busy, o_done, o_error, o_word_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_wr_enable, o_wr_addr, o_wr_data, o_fetch_valid,
               o_busy, o_done, o_error, o_word_count
    );
endinterface

// File: rtl/instruction_loader_byte_packer.sv
// byte_packer: shifts accepted bytes in MSB first and flags the byte that completes a word.
// The packed word is combinational so the caller can latch it on that same edge.
module byte_packer #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic               o_word_done,
    output logic [NB_DATA-1:0] o_word
);
    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_IDX  = $clog2(N_BYTES);

    logic [NB_DATA-NB_BYTE-1:0] shift;
    logic [NB_IDX-1:0]          idx;

    assign o_word_done = i_accept && (idx == NB_IDX'(N_BYTES - 1));
    assign o_word      = {shift, i_byte};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift <= '0;
            idx   <= '0;
        end else if (i_clear) begin
            shift <= '0;
            idx   <= '0;
        end else if (i_accept) begin
            shift <= o_word[NB_DATA-NB_BYTE-1:0];
            idx   <= o_word_done ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: fills instruction memory from the debug UART byte stream, then releases fetch.
// Build option LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the halt word.
module instruction_loader #(
    parameter int                 NB_DATA   = instruction_loader_pkg::NB_DATA,
    parameter int                 NB_BYTE   = instruction_loader_pkg::NB_BYTE,
    parameter int                 NB_ADDR   = instruction_loader_pkg::NB_ADDR,
    parameter logic [NB_DATA-1:0] HALT_WORD = instruction_loader_pkg::HALT_WORD
) (
    input logic                 i_clock,
    input logic                 i_reset,
    instruction_loader_if.slave bus
);
    import instruction_loader_pkg::*;

    state_t             state, state_next;
    logic               error, error_next;
    logic [NB_ADDR-1:0] addr;
    logic [NB_ADDR:0]   count;
    logic               wr_enable;
    logic [NB_DATA-1:0] wr_data;
    logic               start, accept, halt_write, mem_full, word_done;
    logic [NB_DATA-1:0] packed_word;

    assign start      = bus.i_start;
    assign halt_write = wr_enable && (wr_data == HALT_WORD);
    assign mem_full   = wr_enable && (addr == {NB_ADDR{1'b1}});
    // A byte arriving alongside the halt write is the checksum, never part of a new word.
    assign accept     = (state == ST_LOAD) && bus.i_rx_valid && !start && !halt_write;

    byte_packer #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) u_packer (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (start),
        .i_accept    (accept),
        .i_byte      (bus.i_rx_data),
        .o_word_done (word_done),
        .o_word      (packed_word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum;
    logic               csum_bad;

    assign csum_bad = (bus.i_rx_data != csum);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)    csum <= '0;
        else if (start)  csum <= '0;
        else if (accept) csum <= csum ^ bus.i_rx_data;
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            error <= 1'b0;
        end else begin
            state <= state_next;
            error <= error_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a latch.
    always_comb begin
        state_next = state;
        error_next = error;
        if (start) begin
            state_next = ST_LOAD;
            error_next = 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (halt_write) begin
`ifdef LOADER_CHECKSUM_EN
                        if (bus.i_rx_valid) begin
                            state_next = ST_DONE;
                            error_next = csum_bad;
                        end else begin
                            state_next = ST_CHECK;
                        end
`else
                        state_next = ST_DONE;
                        error_next = 1'b0;
`endif
                    end else if (mem_full) begin
                        state_next = ST_DONE;
                        error_next = 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (bus.i_rx_valid) begin
                        state_next = ST_DONE;
                        error_next = csum_bad;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // The address holds the current write target and steps once the write has been presented.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_enable <= 1'b0;
            wr_data   <= '0;
            addr      <= '0;
            count     <= '0;
        end else begin
            wr_enable <= word_done;
            if (word_done) wr_data <= packed_word;
            if (start) begin
                addr  <= '0;
                count <= '0;
            end else if (wr_enable) begin
                addr  <= addr + 1'b1;
                count <= count + 1'b1;
            end
        end
    end

    assign bus.o_wr_enable   = wr_enable;
    assign bus.o_wr_addr     = addr;
    assign bus.o_wr_data     = wr_data;
    assign bus.o_done        = (state == ST_DONE);
    assign bus.o_error       = error;
    assign bus.o_fetch_valid = (state == ST_DONE) && !error;
    assign bus.o_word_count  = count;
`ifdef LOADER_CHECKSUM_EN
    assign bus.o_busy        = (state == ST_LOAD) || (state == ST_CHECK);
`else
    assign bus.o_busy        = (state == ST_LOAD);
`endif
endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed scenarios with random program words, checked against a
// word-level model of the load rules. Honours LOADER_CHECKSUM_EN when it is defined.
module tb_instruction_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef enum int {O_WE, O_ADDR, O_DATA, O_FV, O_BUSY, O_DONE, O_ERR, O_CNT} out_e;

    logic i_clock;
    logic i_reset;

    int checks = 0;
    int errors = 0;

    logic [7:0]  prog[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_error;

    int          wa_addr[$];
    logic [31:0] wa_data[$];
    int          wb_addr[$];
    logic [31:0] wb_data[$];

    instruction_loader_if #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(8)) ifa ();
    instruction_loader_if #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(2)) ifb ();

    instruction_loader #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(8)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (ifa)
    );

    instruction_loader #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(2)) dut_small (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (ifb)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Write monitor: one record per cycle with the write strobe high.
    always @(negedge i_clock) begin
        if (ifa.o_wr_enable === 1'b1) begin
            wa_addr.push_back(int'(ifa.o_wr_addr));
            wa_data.push_back(ifa.o_wr_data);
        end
        if (ifb.o_wr_enable === 1'b1) begin
            wb_addr.push_back(int'(ifb.o_wr_addr));
            wb_data.push_back(ifb.o_wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] obs(input int sel, input out_e which);
        logic [63:0] v;
        v = '0;
        if (sel == 0) begin
            case (which)
                O_WE:    v = 64'(ifa.o_wr_enable);
                O_ADDR:  v = 64'(ifa.o_wr_addr);
                O_DATA:  v = 64'(ifa.o_wr_data);
                O_FV:    v = 64'(ifa.o_fetch_valid);
                O_BUSY:  v = 64'(ifa.o_busy);
                O_DONE:  v = 64'(ifa.o_done);
                O_ERR:   v = 64'(ifa.o_error);
                default: v = 64'(ifa.o_word_count);
            endcase
        end else begin
            case (which)
                O_WE:    v = 64'(ifb.o_wr_enable);
                O_ADDR:  v = 64'(ifb.o_wr_addr);
                O_DATA:  v = 64'(ifb.o_wr_data);
                O_FV:    v = 64'(ifb.o_fetch_valid);
                O_BUSY:  v = 64'(ifb.o_busy);
                O_DONE:  v = 64'(ifb.o_done);
                O_ERR:   v = 64'(ifb.o_error);
                default: v = 64'(ifb.o_word_count);
            endcase
        end
        return v;
    endfunction

    // Present one cycle of inputs starting at a falling edge; returns at the next falling edge.
    task automatic drive(input int sel, input logic s, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            ifa.i_start = s; ifa.i_rx_valid = v; ifa.i_rx_data = d;
        end else begin
            ifb.i_start = s; ifb.i_rx_valid = v; ifb.i_rx_data = d;
        end
        @(negedge i_clock);
    endtask

    task automatic check_zero(input int sel, input string tag);
        for (int o = 0; o < 8; o++)
            check($sformatf("%s_out%0d", tag, o), obs(sel, out_e'(o)), 64'd0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    task automatic add_word(input logic [31:0] w);
        prog.push_back(w[31:24]);
        prog.push_back(w[23:16]);
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
    endtask

    task automatic add_checksum(input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (prog[k]) x ^= prog[k];
        prog.push_back(corrupt ? ~x : x);
`else
        if (corrupt) prog.push_back(8'h00);
`endif
    endtask

    // Reference: words are taken four bytes at a time; the load ends at the halt word or when
    // the last address has been filled with something else.
    task automatic model(input int depth);
        int          i;
        bit          stop;
        logic [31:0] w;
        logic [7:0]  x;
        exp_data.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        i    = 0;
        stop = 1'b0;
        x    = 8'h00;
        while (!stop && (4 * i + 3 < prog.size())) begin
            w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
            x = x ^ prog[4*i] ^ prog[4*i+1] ^ prog[4*i+2] ^ prog[4*i+3];
            exp_data.push_back(w);
            if (w == HALT) begin
                stop = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                if (prog.size() > 4 * i + 4) begin
                    exp_done  = 1'b1;
                    exp_error = (prog[4*i+4] != x);
                end
`else
                exp_done = 1'b1;
`endif
            end else if (i == depth - 1) begin
                stop      = 1'b1;
                exp_done  = 1'b1;
                exp_error = 1'b1;
            end
            i++;
        end
    endtask

    task automatic check_writes(input int sel, input string tag);
        int n;
        n = (sel == 0) ? wa_addr.size() : wb_addr.size();
        check({tag, "_nwrites"}, 64'(n), 64'(exp_data.size()));
        for (int k = 0; k < n && k < exp_data.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), 64'((sel == 0) ? wa_addr[k] : wb_addr[k]), 64'(k));
            check($sformatf("%s_data%0d", tag, k), 64'((sel == 0) ? wa_data[k] : wb_data[k]), 64'(exp_data[k]));
        end
    endtask

    // Start (with a stray byte on the start cycle), stream prog with random gaps, then wait for done.
    task automatic run(input int sel, input int gap_max, input string tag);
        int n;
        model((sel == 0) ? 256 : 4);
        if (sel == 0) begin
            wa_addr.delete(); wa_data.delete();
        end else begin
            wb_addr.delete(); wb_data.delete();
        end
        drive(sel, 1'b1, 1'b1, 8'($urandom));
        check({tag, "_busy_at_start"}, obs(sel, O_BUSY), 64'd1);
        check({tag, "_fv_at_start"},   obs(sel, O_FV),   64'd0);
        foreach (prog[k]) begin
            drive(sel, 1'b0, 1'b1, prog[k]);
            repeat ($urandom_range(gap_max, 0)) drive(sel, 1'b0, 1'b0, 8'h00);
        end
        drive(sel, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (n < 64 && obs(sel, O_DONE) !== 64'd1) begin
            drive(sel, 1'b0, 1'b0, 8'h00);
            n++;
        end
        check({tag, "_done"},  obs(sel, O_DONE), 64'(exp_done));
        check({tag, "_error"}, obs(sel, O_ERR),  64'(exp_error));
        check({tag, "_fv"},    obs(sel, O_FV),   64'(exp_done && !exp_error));
        check({tag, "_busy"},  obs(sel, O_BUSY), 64'd0);
        check({tag, "_count"}, obs(sel, O_CNT),  64'(exp_data.size()));
        check_writes(sel, tag);
    endtask

    initial begin
        ifa.i_start = 1'b0; ifa.i_rx_valid = 1'b0; ifa.i_rx_data = 8'h00;
        ifb.i_start = 1'b0; ifb.i_rx_valid = 1'b0; ifb.i_rx_data = 8'h00;
        i_reset = 1'b0;
        repeat (3) drive(0, 1'b0, 1'b0, 8'h00);
        check_zero(0, "reset_a");
        check_zero(1, "reset_b");
        i_reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00);

        // Minimal program: one word plus halt.
        prog.delete();
        add_word(32'h0000_0001);
        add_word(HALT);
        add_checksum(1'b0);
        run(0, 2, "basic");

        // One byte per clock: three words plus halt.
        prog.delete();
        repeat (3) add_word(rand_word());
        add_word(HALT);
        add_checksum(1'b0);
        run(0, 0, "b2b");

        // Restart after six bytes; the fresh load must begin again at address 0.
        drive(0, 1'b1, 1'b0, 8'h00);
        prog.delete();
        add_word(rand_word());
        prog.push_back(8'($urandom));
        prog.push_back(8'($urandom));
        foreach (prog[k]) drive(0, 1'b0, 1'b1, prog[k]);
        drive(0, 1'b0, 1'b0, 8'h00);
        check("abort_busy", obs(0, O_BUSY), 64'd1);
        check("abort_count", obs(0, O_CNT), 64'd1);
        prog.delete();
        add_word(rand_word());
        add_word(HALT);
        add_checksum(1'b0);
        run(0, 1, "restart");

        // Four-entry memory filled with non-halt words.
        prog.delete();
        repeat (4) add_word(rand_word());
        run(1, 1, "full");
        drive(1, 1'b1, 1'b0, 8'h00);
        check("full_restart_err",  obs(1, O_ERR),  64'd0);
        check("full_restart_done", obs(1, O_DONE), 64'd0);
        check("full_restart_busy", obs(1, O_BUSY), 64'd1);
        drive(1, 1'b0, 1'b0, 8'h00);

`ifdef LOADER_CHECKSUM_EN
        prog.delete();
        add_word(32'h0000_0001);
        add_word(HALT);
        add_checksum(1'b1);
        run(0, 1, "badcks");
`endif

        // Reset while a write is on the bus.
        drive(0, 1'b1, 1'b0, 8'h00);
        prog.delete();
        add_word(rand_word());
        foreach (prog[k]) drive(0, 1'b0, 1'b1, prog[k]);
        check("rst_we_before", obs(0, O_WE), 64'd1);
        i_reset = 1'b0;
        #1;
        check_zero(0, "async_rst");
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(0, 1'b0, 1'b0, 8'h00);
        i_reset = 1'b1;
        wa_addr.delete(); wa_data.delete();
        prog.delete();
        add_word(rand_word());
        add_word(HALT);
        foreach (prog[k]) drive(0, 1'b0, 1'b1, prog[k]);
        repeat (3) drive(0, 1'b0, 1'b0, 8'h00);
        check("idle_busy",    obs(0, O_BUSY), 64'd0);
        check("idle_done",    obs(0, O_DONE), 64'd0);
        check("idle_count",   obs(0, O_CNT),  64'd0);
        check("idle_nwrites", 64'(wa_addr.size()), 64'd0);

        // Random-length program after the reset.
        prog.delete();
        repeat ($urandom_range(5, 2)) add_word(rand_word());
        add_word(HALT);
        add_checksum(1'b0);
        run(0, 3, "rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
